// File: rtl/mux_rr_stream.sv
// Round-robin merge of CHANNELS_COUNT valid/ready streams into one registered output stream.
// With PACKET_MODE=1 the grant sticks to a channel from its first beat until its last beat.
module mux_rr_stream #(
  parameter int unsigned CHANNELS_COUNT = 4,
  parameter int unsigned CHANNELS_WIDTH = 8,
  parameter int unsigned PACKET_MODE    = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [CHANNELS_COUNT-1:0]                      in_valid,
  input  logic [CHANNELS_COUNT-1:0]                      in_last,
  input  logic [CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0]  in_data,
  output logic [CHANNELS_COUNT-1:0]                      in_ready,
  output logic                                           out_valid,
  output logic                                           out_last,
  output logic [CHANNELS_WIDTH-1:0]                      out_data,
  output logic [$clog2(CHANNELS_COUNT)-1:0]              out_channel,
  input  logic                                           out_ready
);

  if (CHANNELS_COUNT < 2) begin : g_bad_count
    $fatal(1, "mux_rr_stream: CHANNELS_COUNT must be >= 2");
  end
  if (CHANNELS_WIDTH < 1) begin : g_bad_width
    $fatal(1, "mux_rr_stream: CHANNELS_WIDTH must be >= 1");
  end

  localparam int unsigned IdxW    = $clog2(CHANNELS_COUNT);
  localparam logic [IdxW:0] NumCh = (IdxW + 1)'(CHANNELS_COUNT);
  localparam bit UseLock          = (PACKET_MODE != 0);

  logic [IdxW-1:0]           ptr_q, lock_ch_q, grant, out_channel_q;
  logic                      lock_q, grant_valid, load_en, accept;
  logic                      out_valid_q, out_last_q;
  logic [CHANNELS_WIDTH-1:0] out_data_q;
  logic [IdxW:0]             cand;

  // Walk the search order backwards so the nearest valid channel after ptr wins.
  always_comb begin
    grant       = lock_ch_q;
    grant_valid = 1'b0;
    cand        = '0;
    if (UseLock && lock_q) begin
      grant_valid = in_valid[lock_ch_q];
    end else begin
      for (int k = CHANNELS_COUNT; k >= 1; k--) begin
        cand = {1'b0, ptr_q} + (IdxW + 1)'(k);
        if (cand >= NumCh) cand = cand - NumCh;
        if (in_valid[cand[IdxW-1:0]]) begin
          grant_valid = 1'b1;
          grant       = cand[IdxW-1:0];
        end
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign accept  = load_en && grant_valid && !rst;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      ptr_q         <= IdxW'(CHANNELS_COUNT - 1);
      lock_q        <= 1'b0;
      lock_ch_q     <= '0;
    end else begin
      if (load_en) out_valid_q <= accept;
      if (accept) begin
        out_last_q    <= in_last[grant];
        out_data_q    <= in_data[grant];
        out_channel_q <= grant;
        if (!UseLock || in_last[grant]) ptr_q <= grant;
        if (UseLock) begin
          lock_q    <= !in_last[grant];
          lock_ch_q <= grant;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: three instances (N=4 packet, N=4 beat, N=3 packet) checked against
// a per-cycle behavioural model, with directed scenarios followed by random traffic.
module tb_mux_rr_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      iv[3], il[3], ir[3];
  logic [3:0][7:0] id[3];
  logic            ordy[3];
  logic            ov[3], ol[3];
  logic [7:0]      od[3];
  logic [1:0]      oc[3];
  logic [3:0]      r0, r1;
  logic [2:0]      r2;

  always_comb begin
    ir[0] = r0;
    ir[1] = r1;
    ir[2] = {1'b0, r2};
  end

  mux_rr_stream #(.CHANNELS_COUNT(4), .CHANNELS_WIDTH(8), .PACKET_MODE(1)) u_pkt (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_last(il[0]), .in_data(id[0]), .in_ready(r0),
    .out_valid(ov[0]), .out_last(ol[0]), .out_data(od[0]), .out_channel(oc[0]),
    .out_ready(ordy[0])
  );

  mux_rr_stream #(.CHANNELS_COUNT(4), .CHANNELS_WIDTH(8), .PACKET_MODE(0)) u_beat (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_last(il[1]), .in_data(id[1]), .in_ready(r1),
    .out_valid(ov[1]), .out_last(ol[1]), .out_data(od[1]), .out_channel(oc[1]),
    .out_ready(ordy[1])
  );

  mux_rr_stream #(.CHANNELS_COUNT(3), .CHANNELS_WIDTH(8), .PACKET_MODE(1)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(iv[2][2:0]), .in_last(il[2][2:0]), .in_data(id[2][2:0]),
    .in_ready(r2), .out_valid(ov[2]), .out_last(ol[2]), .out_data(od[2]),
    .out_channel(oc[2]), .out_ready(ordy[2])
  );

  int unsigned nch[3] = '{4, 4, 3};
  bit          pm[3]  = '{1'b1, 1'b0, 1'b1};

  // Reference state: output register contents, rr pointer, lock owner.
  bit         mv[3], ml[3], mlk[3];
  logic [7:0] md[3];
  int         mc[3], mp[3], mlc[3];

  int total = 0;
  int bad   = 0;
  int seq[3][$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mv[d] = 0; ml[d] = 0; md[d] = '0; mc[d] = 0; mlk[d] = 0; mlc[d] = 0;
      mp[d] = nch[d] - 1;
    end
  endtask

  task automatic drive(int d, logic [3:0] v, logic [3:0] l);
    iv[d] = v;
    il[d] = l;
  endtask

  task automatic check_cleared(string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.dut%0d.valid", tag, d), ov[d], 0);
      chk($sformatf("%s.dut%0d.last", tag, d), ol[d], 0);
      chk($sformatf("%s.dut%0d.data", tag, d), od[d], 0);
      chk($sformatf("%s.dut%0d.chan", tag, d), oc[d], 0);
      chk($sformatf("%s.dut%0d.ready", tag, d), ir[d], 0);
    end
  endtask

  // One clock: check handshake before the edge, advance model, check outputs after it.
  task automatic step();
    bit         nv[3], nl[3], nlk[3];
    logic [7:0] nd[3];
    int         nc[3], np[3], nlc[3];
    #1;
    for (int d = 0; d < 3; d++) begin
      int         g, n;
      bit         gv, le, acc;
      logic [3:0] allow, exp_acc;
      n = nch[d]; g = 0; gv = 0;
      if (pm[d] && mlk[d]) begin
        g  = mlc[d];
        gv = iv[d][g];
      end else begin
        for (int k = 1; k <= n; k++) begin
          int c = (mp[d] + k) % n;
          if (!gv && iv[d][c]) begin
            g  = c;
            gv = 1;
          end
        end
      end
      le      = !mv[d] || ordy[d];
      acc     = le && gv;
      exp_acc = acc ? 4'(1 << g) : 4'b0;
      allow   = exp_acc;
      if (!acc && pm[d] && mlk[d]) allow = 4'(1 << mlc[d]);
      chk($sformatf("dut%0d.accept", d), iv[d] & ir[d], exp_acc);
      chk($sformatf("dut%0d.stray_ready", d), ir[d] & ~allow, 0);
      nv[d] = mv[d]; nl[d] = ml[d]; nd[d] = md[d]; nc[d] = mc[d];
      np[d] = mp[d]; nlk[d] = mlk[d]; nlc[d] = mlc[d];
      if (acc) begin
        nv[d] = 1; nl[d] = il[d][g]; nd[d] = id[d][g]; nc[d] = g;
        if (!pm[d] || il[d][g]) np[d] = g;
        if (pm[d]) begin
          nlk[d] = !il[d][g];
          nlc[d] = g;
        end
      end else if (le) begin
        nv[d] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      mv[d] = nv[d]; ml[d] = nl[d]; md[d] = nd[d]; mc[d] = nc[d];
      mp[d] = np[d]; mlk[d] = nlk[d]; mlc[d] = nlc[d];
      chk($sformatf("dut%0d.out_valid", d), ov[d], mv[d]);
      if (mv[d]) begin
        chk($sformatf("dut%0d.out_last", d), ol[d], ml[d]);
        chk($sformatf("dut%0d.out_data", d), od[d], md[d]);
        chk($sformatf("dut%0d.out_channel", d), oc[d], mc[d]);
      end
      if (ov[d]) seq[d].push_back(int'(oc[d]));
    end
    @(negedge clk);
  endtask

  task automatic check_seq(string tag, int d, int exp[$]);
    chk({tag, ".len"}, seq[d].size(), exp.size());
    for (int i = 0; i < exp.size() && i < seq[d].size(); i++)
      chk($sformatf("%s[%0d]", tag, i), seq[d][i], exp[i]);
  endtask

  initial begin
    logic [1:0] c0;
    logic [7:0] d0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 4'b0, 4'b0);
      ordy[d] = 1'b1;
      for (int i = 0; i < 4; i++) id[d][i] = 8'(8'hA0 + 16 * d + i);
    end
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill outputs, then pulse reset between edges with inputs still valid.
    for (int d = 0; d < 3; d++) drive(d, 4'b1111, 4'b1111);
    repeat (2) step();
    #2 rst = 1'b1;
    #1 check_cleared("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Round robin with all channels valid; first grant goes to ch0.
    for (int d = 0; d < 3; d++) seq[d].delete();
    drive(0, 4'b0000, 4'b0000);
    repeat (6) step();
    check_seq("rr4", 1, '{0, 1, 2, 3, 0, 1});
    check_seq("rr3", 2, '{0, 1, 2, 0, 1, 2});

    // Packet lock: ch2 holds the grant for three beats while ch0 waits.
    drive(1, 4'b0000, 4'b0000);
    drive(2, 4'b0000, 4'b0000);
    seq[0].delete();
    drive(0, 4'b0100, 4'b0000); step();
    drive(0, 4'b0101, 4'b0001); step();
    drive(0, 4'b0101, 4'b0101); step();
    drive(0, 4'b0001, 4'b0001); step();
    check_seq("pkt_lock", 0, '{2, 2, 2, 0});

    // Owner goes idle mid-packet: bubbles, and ch3 must wait for ch1's last beat.
    seq[0].delete();
    drive(0, 4'b0010, 4'b0000); step();
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'b1000, 4'b1000);
      step();
      chk("idle_owner.out_valid", ov[0], 0);
    end
    drive(0, 4'b1010, 4'b1010); step();
    drive(0, 4'b1000, 4'b1000); step();
    check_seq("idle_owner", 0, '{1, 1, 3});
    drive(0, 4'b0000, 4'b0000);

    // Backpressure: output held, no ready; release reloads on the draining edge.
    drive(1, 4'b1111, 4'b1111);
    step();
    c0 = oc[1];
    d0 = od[1];
    ordy[1] = 1'b0;
    repeat (3) begin
      step();
      chk("bp.hold_chan", oc[1], c0);
      chk("bp.hold_data", od[1], d0);
      chk("bp.ready", ir[1], 0);
    end
    ordy[1] = 1'b1;
    step();
    chk("bp.no_bubble", ov[1], 1);
    chk("bp.next_chan", oc[1], 2'(c0 + 2'd1));
    drive(1, 4'b0000, 4'b0000);

    // Reset during a locked packet on N=3 clears the lock; ch0 wins next.
    drive(2, 4'b0010, 4'b0000); step();
    drive(2, 4'b0111, 4'b0000);
    #2 rst = 1'b1;
    #1 check_cleared("mid_pkt_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(2, 4'b0111, 4'b0111);
    step();
    chk("mid_pkt_rst.valid", ov[2], 1);
    chk("mid_pkt_rst.chan", oc[2], 0);

    // Random traffic on all three instances.
    for (int t = 0; t < 500; t++) begin
      for (int d = 0; d < 3; d++) begin
        drive(d, 4'($urandom), 4'($urandom));
        ordy[d] = ($urandom_range(3) != 0);
        for (int i = 0; i < 4; i++) id[d][i] = 8'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
